// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor, one DATA_W/STAGES-bit slice per stage; latency STAGES cycles.
// One global enable stalls every stage together while a result waits for ready_i; bubbles are kept.
module pipelined_addsub #(
   parameter int DATA_W = 32,
   parameter int STAGES = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              cin_i,
   input  logic              sub_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              cout_o,
   output logic              ovf_o
);
   localparam int SW = DATA_W / STAGES;

   if ((DATA_W % STAGES) != 0) begin : g_bad_split
      $error("DATA_W must be a multiple of STAGES");
   end

   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] cy_q;
   logic [STAGES-1:0] cy_d;
   logic              ovf_q;
   logic              ovf_d;
   logic [DATA_W-1:0] a_q [STAGES];
   logic [DATA_W-1:0] b_q [STAGES];
   logic [DATA_W-1:0] s_q [STAGES];
   logic [DATA_W-1:0] a_d [STAGES];
   logic [DATA_W-1:0] b_d [STAGES];
   logic [DATA_W-1:0] s_d [STAGES];
   logic              en;

   assign en      = ready_i | ~vld_q[STAGES-1];
   assign ready_o = en;

   // Skew registers shift right so the next slice is always at bit 0; finished
   // sum slices enter at the top and reach their final position after the last stage.
   always_comb begin
      logic [DATA_W-1:0] a_in;
      logic [DATA_W-1:0] b_in;
      logic [DATA_W-1:0] s_in;
      logic              c_in;
      logic [SW:0]       r;
      a_in  = '0;
      b_in  = '0;
      s_in  = '0;
      c_in  = 1'b0;
      r     = '0;
      a_d   = '{default: '0};
      b_d   = '{default: '0};
      s_d   = '{default: '0};
      cy_d  = '0;
      ovf_d = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            a_in = a_i;
            b_in = sub_i ? ~b_i : b_i;
            c_in = cin_i ^ sub_i;
            s_in = '0;
         end else begin
            a_in = a_q[k-1];
            b_in = b_q[k-1];
            c_in = cy_q[k-1];
            s_in = s_q[k-1];
         end
         r       = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};
         a_d[k]  = a_in >> SW;
         b_d[k]  = b_in >> SW;
         s_d[k]  = (DATA_W'(r[SW-1:0]) << (DATA_W - SW)) | (s_in >> SW);
         cy_d[k] = r[SW];
         if (k == STAGES - 1) begin
            ovf_d = (a_in[SW-1] == b_in[SW-1]) && (r[SW-1] != a_in[SW-1]);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         cy_q  <= '0;
         ovf_q <= 1'b0;
         a_q   <= '{default: '0};
         b_q   <= '{default: '0};
         s_q   <= '{default: '0};
      end else if (en) begin
         vld_q <= (vld_q << 1) | STAGES'(valid_i);
         cy_q  <= cy_d;
         ovf_q <= ovf_d;
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
      end
   end

   assign valid_o = vld_q[STAGES-1];
   assign sum_o   = valid_o ? s_q[STAGES-1] : '0;
   assign cout_o  = valid_o & cy_q[STAGES-1];
   assign ovf_o   = valid_o & ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: three instances (STAGES 4, 1, 32) share one input stream.
module tb_pipelined_addsub;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i, ready_i, cin, sub;
   logic [31:0] a, b;
   logic        ro [3];
   logic        vo [3];
   logic        co [3];
   logic        ov [3];
   logic [31:0] so [3];
   int          total = 0;
   int          bad = 0;
   int          exp_lat [3] = '{3, 0, 31};

   always #5 clk = ~clk;

   pipelined_addsub #(.DATA_W(32), .STAGES(4)) dut_s4 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ro[0]), .a_i(a), .b_i(b),
      .cin_i(cin), .sub_i(sub), .valid_o(vo[0]), .ready_i(ready_i), .sum_o(so[0]),
      .cout_o(co[0]), .ovf_o(ov[0]));
   pipelined_addsub #(.DATA_W(32), .STAGES(1)) dut_s1 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ro[1]), .a_i(a), .b_i(b),
      .cin_i(cin), .sub_i(sub), .valid_o(vo[1]), .ready_i(ready_i), .sum_o(so[1]),
      .cout_o(co[1]), .ovf_o(ov[1]));
   pipelined_addsub #(.DATA_W(32), .STAGES(32)) dut_s32 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ro[2]), .a_i(a), .b_i(b),
      .cin_i(cin), .sub_i(sub), .valid_o(vo[2]), .ready_i(ready_i), .sum_o(so[2]),
      .cout_o(co[2]), .ovf_o(ov[2]));

   // Reference: {ovf, cout, sum} from a flat 33-bit add.
   function automatic logic [33:0] model(input logic [31:0] ta, tb, input logic tc, ts);
      logic [31:0] be;
      logic [32:0] r;
      be = ts ? ~tb : tb;
      r  = {1'b0, ta} + {1'b0, be} + {32'd0, tc ^ ts};
      return {(ta[31] == be[31]) && (r[31] != ta[31]), r};
   endfunction

   // Sends one op with ready_i high and waits for the first valid_o on instance sel.
   task automatic run_op(input int sel, input logic [31:0] ta, tb, input logic tc, ts,
                         output logic [31:0] rs, output logic rc, rv, output int lat);
      @(posedge clk); #1;
      a = ta; b = tb; cin = tc; sub = ts; valid_i = 1'b1; ready_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      lat = 0;
      while (vo[sel] !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 64) lat = -1;
      rs = so[sel]; rc = co[sel]; rv = ov[sel];
   endtask

   task automatic test_reset;
      rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         total++; if (vo[i] !== 1'b0) begin bad++; $display("FAIL rst_valid[%0d] got=%b want=0", i, vo[i]); end
         total++; if (so[i] !== 32'h0) begin bad++; $display("FAIL rst_sum[%0d] got=%h want=0", i, so[i]); end
         total++; if (co[i] !== 1'b0) begin bad++; $display("FAIL rst_cout[%0d] got=%b want=0", i, co[i]); end
         total++; if (ov[i] !== 1'b0) begin bad++; $display("FAIL rst_ovf[%0d] got=%b want=0", i, ov[i]); end
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (ro[0] !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ro[0]); end
   endtask

   task automatic test_add_carry;
      logic [31:0] s; logic c, v; int lat;
      run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, v, lat);
      total++; if (s !== 32'h0) begin bad++; $display("FAIL carry_sum got=%h want=00000000", s); end
      total++; if (c !== 1'b1) begin bad++; $display("FAIL carry_cout got=%b want=1", c); end
      total++; if (v !== 1'b0) begin bad++; $display("FAIL carry_ovf got=%b want=0", v); end
      total++; if (lat !== 3) begin bad++; $display("FAIL carry_latency got=%0d want=3", lat); end
      @(posedge clk); #1;
      total++; if (vo[0] !== 1'b0) begin bad++; $display("FAIL carry_single got=%b want=0", vo[0]); end
   endtask

   task automatic test_add_ovf;
      logic [31:0] s; logic c, v; int lat;
      run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, v, lat);
      total++; if (s !== 32'h8000_0000) begin bad++; $display("FAIL ovf_sum got=%h want=80000000", s); end
      total++; if (c !== 1'b0) begin bad++; $display("FAIL ovf_cout got=%b want=0", c); end
      total++; if (v !== 1'b1) begin bad++; $display("FAIL ovf_ovf got=%b want=1", v); end
   endtask

   task automatic test_sub;
      logic [31:0] s; logic c, v; int lat;
      run_op(0, 32'd5, 32'd7, 1'b0, 1'b1, s, c, v, lat);
      total++; if ({v, c, s} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin
         bad++; $display("FAIL sub_5_7 got=%b/%b/%h want=0/0/fffffffe", v, c, s); end
      run_op(0, 32'h8000_0000, 32'd1, 1'b0, 1'b1, s, c, v, lat);
      total++; if ({v, c, s} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin
         bad++; $display("FAIL sub_min_1 got=%b/%b/%h want=1/1/7fffffff", v, c, s); end
   endtask

   task automatic test_carry_in;
      logic [31:0] s; logic c, v; int lat;
      run_op(0, 32'h10, 32'h20, 1'b1, 1'b0, s, c, v, lat);
      total++; if ({v, c, s} !== {1'b0, 1'b0, 32'h31}) begin
         bad++; $display("FAIL cin_add got=%b/%b/%h want=0/0/00000031", v, c, s); end
      run_op(0, 32'd10, 32'd3, 1'b1, 1'b1, s, c, v, lat);
      total++; if ({v, c, s} !== {1'b0, 1'b1, 32'd6}) begin
         bad++; $display("FAIL cin_sub got=%b/%b/%h want=0/1/00000006", v, c, s); end
   endtask

   task automatic test_slice_carry;
      logic [31:0] s; logic c, v; int lat;
      run_op(0, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, s, c, v, lat);
      total++; if (s !== 32'h0000_0100) begin bad++; $display("FAIL slice_8 got=%h want=00000100", s); end
      run_op(0, 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, s, c, v, lat);
      total++; if (s !== 32'h0001_0000) begin bad++; $display("FAIL slice_16 got=%h want=00010000", s); end
      run_op(0, 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, s, c, v, lat);
      total++; if (s !== 32'h0100_0000) begin bad++; $display("FAIL slice_24 got=%h want=01000000", s); end
   endtask

   task automatic test_stall;
      int n;
      @(posedge clk); #1;
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
      @(posedge clk); #1;
      valid_i = 1'b0;
      n = 0;
      while (vo[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (n !== 3) begin bad++; $display("FAIL stall_latency got=%0d want=3", n); end
      for (int i = 0; i < 3; i++) begin
         total++; if ({vo[0], so[0]} !== {1'b1, 32'h2345_6789}) begin
            bad++; $display("FAIL stall_hold[%0d] got=%b/%h want=1/23456789", i, vo[0], so[0]); end
         total++; if (ro[0] !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0", i, ro[0]); end
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      #1;
      total++; if (ro[0] !== 1'b1) begin bad++; $display("FAIL stall_ready_comb got=%b want=1", ro[0]); end
      @(posedge clk); #1;
      total++; if (vo[0] !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", vo[0]); end
   endtask

   task automatic test_stream;
      logic [31:0] qa [16];
      logic [31:0] qb [16];
      logic        qc [16];
      logic        qs [16];
      logic [33:0] want;
      logic [33:0] hold;
      logic        stall_prev, acc, xfer;
      int          sent, recv, cyc;
      for (int i = 0; i < 16; i++) begin
         qa[i] = $urandom; qb[i] = $urandom; qc[i] = 1'($urandom_range(0, 1)); qs[i] = 1'($urandom_range(0, 1));
      end
      qa[0] = 32'h7FFF_FFFF; qb[0] = 32'h1; qc[0] = 1'b0; qs[0] = 1'b0;
      sent = 0; recv = 0; cyc = 0; stall_prev = 1'b0; hold = '0;
      while (recv < 16 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         ready_i = 1'($urandom_range(0, 1));
         valid_i = (sent < 16);
         if (sent < 16) begin a = qa[sent]; b = qb[sent]; cin = qc[sent]; sub = qs[sent]; end
         #1;
         if (stall_prev) begin
            total++; if ({vo[0], ov[0], co[0], so[0]} !== {1'b1, hold}) begin
               bad++; $display("FAIL stream_stable cyc=%0d got=%b/%h want=1/%h", cyc, vo[0], {ov[0], co[0], so[0]}, hold); end
         end
         total++; if (ro[0] !== (ready_i | ~vo[0])) begin
            bad++; $display("FAIL stream_ready cyc=%0d got=%b want=%b", cyc, ro[0], ready_i | ~vo[0]); end
         acc  = valid_i & ro[0];
         xfer = vo[0] & ready_i;
         if (xfer) begin
            want = model(qa[recv], qb[recv], qc[recv], qs[recv]);
            total++; if ({ov[0], co[0], so[0]} !== want) begin
               bad++; $display("FAIL stream_result[%0d] got=%h want=%h", recv, {ov[0], co[0], so[0]}, want); end
            recv++;
         end
         if (acc) sent++;
         stall_prev = vo[0] & ~ready_i;
         hold = {ov[0], co[0], so[0]};
      end
      valid_i = 1'b0; ready_i = 1'b1;
      total++; if (recv !== 16) begin bad++; $display("FAIL stream_count got=%0d want=16", recv); end
   endtask

   task automatic test_reset_inflight;
      int          lat [3];
      logic [31:0] got [3];
      logic        seen [3];
      valid_i = 1'b0; ready_i = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         a = 32'h100 * (i + 1); b = 32'h3; cin = 1'b0; sub = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
         @(posedge clk); #1;
      end
      valid_i = 1'b0; ready_i = 1'b0;
      @(posedge clk); #1;
      total++; if ({vo[0], vo[1]} !== 2'b11) begin bad++; $display("FAIL inflight_pre got=%b%b want=11", vo[0], vo[1]); end
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++; if (vo[i] !== 1'b0) begin bad++; $display("FAIL inflight_drop[%0d] got=%b want=0", i, vo[i]); end
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      ready_i = 1'b1;
      seen = '{default: 1'b0};
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) if (vo[i] !== 1'b0) seen[i] = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         total++; if (seen[i] !== 1'b0) begin bad++; $display("FAIL inflight_ghost[%0d] got=1 want=0", i); end
      end
      a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      lat = '{default: -1};
      got = '{default: '0};
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < 3; i++) if (vo[i] === 1'b1 && lat[i] < 0) begin lat[i] = c; got[i] = so[i]; end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
         total++; if (lat[i] !== exp_lat[i]) begin bad++; $display("FAIL after_rst_lat[%0d] got=%0d want=%0d", i, lat[i], exp_lat[i]); end
         total++; if (got[i] !== 32'h0001_0000) begin bad++; $display("FAIL after_rst_sum[%0d] got=%h want=00010000", i, got[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_add_ovf();
      test_sub();
      test_carry_in();
      test_slice_carry();
      test_stall();
      test_stream();
      test_reset_inflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
